// File: rtl/serial_mag_cmp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
// The FSM state encoding and the default operand width live here.
package serial_mag_cmp_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } result_t;

endpackage

// File: rtl/serial_mag_cmp_bit_cmp_cell.sv
// Combinational 1-bit comparison cell; swap reverses the lt/gt sense so that
// a set sign bit reads as the smaller operand.
module bit_cmp_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic swap,
    output logic eq_bit,
    output logic lt_bit,
    output logic gt_bit
);

    logic a_only;
    logic b_only;

    assign a_only = a_bit & ~b_bit;
    assign b_only = ~a_bit & b_bit;

    assign eq_bit = ~(a_bit ^ b_bit);
    assign lt_bit = swap ? a_only : b_only;
    assign gt_bit = swap ? b_only : a_only;

endmodule

// File: rtl/serial_mag_cmp.sv
// Bit-serial magnitude comparator: scans captured operands MSB first, one bit
// per clock, and stops at the first differing bit or after the LSB.
module serial_mag_cmp
    import serial_mag_cmp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int                IDX_W   = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             signed_q;
    result_t          res_q;

    logic accept;
    logic scanning;
    logic last_bit;
    logic finish;
    logic swap;
    logic eq_bit;
    logic lt_bit;
    logic gt_bit;

    assign accept   = start & (state_q != SCAN);
    assign scanning = (state_q == SCAN);
    assign last_bit = (idx_q == '0);
    assign finish   = scanning & (~eq_bit | last_bit);
    assign swap     = signed_q & (idx_q == IDX_MSB);

    bit_cmp_cell u_cell (
        .a_bit  (a_q[idx_q]),
        .b_bit  (b_q[idx_q]),
        .swap   (swap),
        .eq_bit (eq_bit),
        .lt_bit (lt_bit),
        .gt_bit (gt_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output takes a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? SCAN : IDLE;
            SCAN:    state_d = (~eq_bit | last_bit) ? DONE : SCAN;
            DONE:    state_d = start ? SCAN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the operand registers are ordinary flops, so they are cleared by reset like the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            res_q    <= '0;
        end else begin
            if (accept) begin
                a_q      <= a;
                b_q      <= b;
                signed_q <= signed_mode;
                idx_q    <= IDX_MSB;
            end else if (scanning && eq_bit && !last_bit) begin
                idx_q <= idx_q - IDX_ONE;
            end

            // Flags change only when a scan concludes; they hold otherwise.
            if (finish) begin
                res_q.lt <= lt_bit;
                res_q.eq <= eq_bit;
                res_q.gt <= gt_bit;
            end
        end
    end

    assign busy = (state_q == SCAN);
    assign done = (state_q == DONE);
    assign lt   = res_q.lt;
    assign eq   = res_q.eq;
    assign gt   = res_q.gt;

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Self-checking bench for serial_mag_cmp: directed corner cases followed by a
// randomized regression against an arithmetic reference compare.
module tb_serial_mag_cmp;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         signed_mode;
    logic         busy;
    logic         done;
    logic         lt;
    logic         eq;
    logic         gt;

    int n_checks = 0;
    int n_pass   = 0;

    serial_mag_cmp #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .lt          (lt),
        .eq          (eq),
        .gt          (gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference result {lt, eq, gt} from plain signed/unsigned arithmetic.
    function automatic logic [2:0] ref_flags(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic sm);
        logic signed [W:0] xv;
        logic signed [W:0] yv;
        xv = sm ? {x[W-1], x} : {1'b0, x};
        yv = sm ? {y[W-1], y} : {1'b0, y};
        return {xv < yv, xv == yv, xv > yv};
    endfunction

    // Edges from start acceptance to done: one plus the leading equal bits, capped.
    function automatic int ref_latency(input logic [W-1:0] x, input logic [W-1:0] y);
        int j;
        j = 0;
        for (int i = W - 1; i >= 1; i--) begin
            if (x[i] != y[i]) break;
            j++;
        end
        return 1 + j;
    endfunction

    // Waits for done after the acceptance edge; k = edges since acceptance.
    task automatic wait_done(output int k, output int busy_cnt, output logic busy_at_done);
        k            = 0;
        busy_cnt     = 0;
        busy_at_done = 1'b0;
        while (k <= W + 2) begin
            if (done) begin
                busy_at_done = busy;
                return;
            end
            if (busy) busy_cnt++;
            step();
            k++;
        end
    endtask

    task automatic run_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm,
                           input string tag);
        int         k;
        int         bcnt;
        logic       bad;
        logic [2:0] exp_f;
        int         exp_lat;
        exp_f   = ref_flags(x, y, sm);
        exp_lat = ref_latency(x, y);
        start       = 1'b1;
        a           = x;
        b           = y;
        signed_mode = sm;
        step();
        start = 1'b0;
        a     = ~x;
        b     = ~y;
        wait_done(k, bcnt, bad);
        check({tag, " latency"}, k, exp_lat);
        check({tag, " busy_cycles"}, bcnt, exp_lat);
        check({tag, " busy_with_done"}, bad, 1'b0);
        check({tag, " flags"}, {lt, eq, gt}, exp_f);
        check({tag, " onehot"}, $countones({lt, eq, gt}), 1);
        step();
        check({tag, " idle_hold"}, {busy, done, lt, eq, gt}, {2'b00, exp_f});
    endtask

    initial begin
        int         k;
        int         bcnt;
        int         done_seen;
        logic       bad;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic       rs;

        rst         = 1'b1;
        start       = 1'b0;
        a           = '0;
        b           = '0;
        signed_mode = 1'b0;
        #12;
        check("reset_outputs", {busy, done, lt, eq, gt}, 5'b0);
        step();
        rst = 1'b0;
        step();
        check("idle_after_reset", {busy, done}, 2'b00);

        run_cmp(8'h80, 8'h7F, 1'b0, "msb_diff");
        run_cmp(8'h5A, 8'h5A, 1'b0, "equal");
        run_cmp(8'h80, 8'h01, 1'b1, "signed_neg");
        run_cmp(8'h80, 8'h01, 1'b0, "unsigned_big");
        run_cmp(8'hFF, 8'hFE, 1'b1, "signed_lsb");

        // Back-to-back: start held through SCAN, operands changed mid-scan.
        start       = 1'b1;
        a           = 8'h12;
        b           = 8'h13;
        signed_mode = 1'b0;
        step();
        a = 8'h13;
        b = 8'h12;
        wait_done(k, bcnt, bad);
        check("b2b_first_latency", k, 8);
        check("b2b_first_flags", {lt, eq, gt}, 3'b100);
        step();
        check("b2b_no_idle", {busy, done}, 2'b10);
        start = 1'b0;
        wait_done(k, bcnt, bad);
        check("b2b_second_latency", k, 8);
        check("b2b_second_flags", {lt, eq, gt}, 3'b001);
        step();

        // Reset in the middle of a scan.
        start = 1'b1;
        a     = 8'h00;
        b     = 8'h01;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("abort_busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_outputs", {busy, done, lt, eq, gt}, 5'b0);
        step();
        rst       = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) done_seen++;
            step();
        end
        check("abort_no_done", done_seen, 0);
        run_cmp(8'h00, 8'h01, 1'b0, "after_abort");

        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            rs = 1'($urandom_range(0, 1));
            run_cmp(ra, rb, rs, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
